pending_priority_encoder: RTL and testbench
===========================================

Name: pending_priority_encoder

Overview:
- Parametrised, registered successor to the team's 10-input decimal-to-BCD priority encoder.
- Captures one-cycle request pulses on N lines into sticky pending bits.
- Issues the winning index through a registered valid/ready output slot, and clears each bit once it is issued.
- Selection is fixed-priority (highest index wins) or round-robin, chosen by parameter. Sits between interrupt/keypad-style request sources and a consumer that can stall.

Parameters:
- N, 10: number of request lines (2..64).
- W, $clog2(N): index width. Derived; must not be overridden.
- ROUND_ROBIN, 0: 0 = fixed priority with index N-1 highest; 1 = rotating priority.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- clr  in  1  synchronous clear of all state
- req  in  N  request pulses; a 1 sets the matching pending bit
- out_valid  out  1  output slot holds an issued index
- out_ready  in  1  consumer accepts out_idx when out_valid && out_ready
- out_idx  out  W  issued index; binary, 0..N-1
- pending  out  N  requests captured but not yet issued
- overflow  out  1  sticky: a request arrived on a bit that was already pending

Behaviour:
- Reset (rst_n=0, async): pending=0, out_valid=0, out_idx=0, overflow=0, rr pointer=N-1.
- clr=1 (sync): produces the same state as reset on the next edge. clr beats req in the same cycle.
- Pending update, per edge: pending <= (pending & ~load_mask) | req.
  - load_mask is the one-hot bit of the index loaded into the slot this cycle.
  - A set wins over a clear: a req on the bit being loaded leaves it pending as a new request.
- Slot load: slot_free = !out_valid || out_ready.
  - If slot_free and pending != 0: the slot loads the selected index and sets out_valid=1.
  - If slot_free and pending == 0: out_valid <= 0.
  - If the slot is not free: out_idx and out_valid hold stable. Backpressure never corrupts out_idx.
- Latency:
  - A req sampled at edge k appears in pending after edge k.
  - It is issued earliest after edge k+1, i.e. 2 cycles.
  - Sustained throughput is one index per cycle while out_ready=1.
- Fixed selection: the highest set bit of pending.
- Round-robin selection:
  - Search order is ptr, ptr-1, ..., 0, N-1, ..., ptr+1; the first set bit wins.
  - After loading index i: ptr <= (i==0) ? N-1 : i-1.
  - ptr updates only on a load.
- overflow <= 1 when, for any bit b, req[b] && pending[b] && !load_mask[b]. It is cleared only by reset or clr.
- req bits on an index that is currently in the slot only set pending; this is not counted as overflow.
- No X on any output. out_idx is always < N.

Decomposition:
- Package pending_pe_pkg holds mode constants (PE_FIXED=0, PE_RR=1) and the function idx_to_onehot.
- Sub-module prio_select (combinational):
  - inputs: vec[N], ptr[W], rr
  - outputs: any, idx[W]
  - Implements both search orders, using a doubled-vector mask method for round-robin.
- The top level holds the pending, slot, ptr and overflow registers.

Test Plan:
- Reset: rst_n low mid-stream with out_valid=1 and pending=10'h0F0. Required: out_valid=0, out_idx=0, pending=0 and overflow=0 immediately, without waiting for a clock edge.
- Fixed mode, N=10, out_ready=1. Stimulus: req=10'b0000100101 for one cycle at edge k. Required: out_idx 5,2,0 on the cycles after edges k+1, k+2, k+3; out_valid=0 after edge k+4.
- Backpressure, fixed mode. Stimulus: req=10'b1000001000 pulse, out_ready=0 for 5 cycles. Required: out_idx=9 held with out_valid=1 and pending=10'b0000001000. Then out_ready=1 gives 3, then out_valid=0.
- Round-robin, N=10, req=all ones held, out_ready=1. Required: out_idx 9,8,...,0,9,8; overflow=1 from the second cycle.
- Fixed mode, same stimulus as the round-robin case. Required: out_idx=9 every cycle.
- Overflow and clear. Stimulus: req[3] pulsed at edges k and k+1 while out_ready=0 and the slot holds another index. Required: overflow=1. Then clr=1 together with req=10'h001 gives pending=0, overflow=0 and out_valid=0 on the next cycle.

Source files
------------

// File: rtl/pending_pe_pkg.sv
// Shared constants and helpers for the pending-request priority encoder.
// Mode values select the search order used by prio_select.
package pending_pe_pkg;

    localparam int PE_FIXED = 0;
    localparam int PE_RR    = 1;
    localparam int PE_MAX_N = 64;
    localparam int PE_MAX_W = 6;

    // One-hot decode sized for the largest supported N; callers truncate.
    function automatic logic [PE_MAX_N-1:0] idx_to_onehot(input logic [PE_MAX_W-1:0] idx);
        logic [PE_MAX_N-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/pending_priority_encoder_prio_select.sv
// Combinational winner selection over a request vector: fixed highest-index
// priority, or a round-robin search that starts at ptr and walks downward.
module prio_select #(
    parameter int N = 10,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] vec_i,
    input  logic [W-1:0] ptr_i,
    input  logic         rr_i,
    output logic         any_o,
    output logic [W-1:0] idx_o
);

    logic [2*N-1:0] dbl_vec;
    logic [2*N-1:0] win_mask;
    logic [2*N-1:0] masked_vec;
    logic [W-1:0]   fix_idx;
    logic [W-1:0]   rr_idx;

    // Window (ptr, ptr+N] of the doubled vector is the rotated search order.
    assign dbl_vec = {vec_i, vec_i};

    generate
        for (genvar gi = 0; gi < 2*N; gi++) begin : g_win
            assign win_mask[gi] = (gi > int'(ptr_i)) && (gi <= int'(ptr_i) + N);
        end
    endgenerate

    assign masked_vec = dbl_vec & win_mask;

    always_comb begin
        fix_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (vec_i[i]) begin
                fix_idx = W'(i);
            end
        end
    end

    always_comb begin
        rr_idx = '0;
        for (int p = 0; p < 2*N; p++) begin
            if (masked_vec[p]) begin
                rr_idx = (p >= N) ? W'(p - N) : W'(p);
            end
        end
    end

    assign any_o = |vec_i;
    assign idx_o = rr_i ? rr_idx : fix_idx;

endmodule

// File: rtl/pending_priority_encoder.sv
// Sticky pending-request capture feeding a registered valid/ready index slot.
// Each captured request is issued once, highest-index-first or round-robin.
module pending_priority_encoder
    import pending_pe_pkg::*;
#(
    parameter int N           = 10,
    parameter int W           = $clog2(N),
    parameter int ROUND_ROBIN = 0
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic [N-1:0] req_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_idx_o,
    output logic [N-1:0] pending_o,
    output logic         overflow_o
);

    localparam logic         RR_MODE = (ROUND_ROBIN == PE_RR);
    localparam logic [W-1:0] PTR_RST = W'(N - 1);

    logic [N-1:0] pending_q,   pending_d;
    logic         out_valid_q, out_valid_d;
    logic [W-1:0] out_idx_q,   out_idx_d;
    logic [W-1:0] ptr_q,       ptr_d;
    logic         overflow_q,  overflow_d;

    logic         sel_any;
    logic [W-1:0] sel_idx;
    logic         slot_free;
    logic         load;
    logic [N-1:0] load_mask;

    prio_select #(
        .N (N),
        .W (W)
    ) u_sel (
        .vec_i (pending_q),
        .ptr_i (ptr_q),
        .rr_i  (RR_MODE),
        .any_o (sel_any),
        .idx_o (sel_idx)
    );

    assign slot_free = !out_valid_q || out_ready_i;
    assign load      = slot_free && sel_any;
    assign load_mask = load ? N'(idx_to_onehot(PE_MAX_W'(sel_idx))) : '0;

    always_comb begin
        pending_d   = (pending_q & ~load_mask) | req_i;
        overflow_d  = overflow_q | (|(req_i & pending_q & ~load_mask));
        out_valid_d = out_valid_q;
        out_idx_d   = out_idx_q;
        ptr_d       = ptr_q;

        // A stalled slot keeps its index; only a free slot may load or drain.
        if (slot_free) begin
            out_valid_d = sel_any;
            if (sel_any) begin
                out_idx_d = sel_idx;
                ptr_d     = (sel_idx == '0) ? PTR_RST : sel_idx - 1'b1;
            end
        end

        if (clr_i) begin
            pending_d   = '0;
            overflow_d  = 1'b0;
            out_valid_d = 1'b0;
            out_idx_d   = '0;
            ptr_d       = PTR_RST;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending_q   <= '0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            ptr_q       <= PTR_RST;
            overflow_q  <= 1'b0;
        end else begin
            pending_q   <= pending_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            ptr_q       <= ptr_d;
            overflow_q  <= overflow_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_idx_o   = out_idx_q;
    assign pending_o   = pending_q;
    assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_pending_priority_encoder.sv
// Bench for pending_priority_encoder: a fixed-priority and a round-robin
// instance share stimulus and are checked every cycle against a queue model.
module tb_pending_priority_encoder;

    localparam int N = 10;
    localparam int W = $clog2(N);

    typedef struct packed {
        logic [N-1:0] pend;
        logic         valid;
        int           idx;
        int           ptr;
        logic         ovf;
    } model_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         clr = 1'b0;
    logic [N-1:0] req = '0;
    logic         out_ready = 1'b0;

    logic         fx_valid, rr_valid;
    logic [W-1:0] fx_idx,   rr_idx;
    logic [N-1:0] fx_pend,  rr_pend;
    logic         fx_ovf,   rr_ovf;

    model_t m_fx, m_rr;
    bit     chk_en = 1'b0;
    int     n_checks = 0;
    int     n_pass = 0;

    always #5 clk = ~clk;

    pending_priority_encoder #(.N(N), .ROUND_ROBIN(0)) u_fix (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .clr_i       (clr),
        .req_i       (req),
        .out_valid_o (fx_valid),
        .out_ready_i (out_ready),
        .out_idx_o   (fx_idx),
        .pending_o   (fx_pend),
        .overflow_o  (fx_ovf)
    );

    pending_priority_encoder #(.N(N), .ROUND_ROBIN(1)) u_rr (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .clr_i       (clr),
        .req_i       (req),
        .out_valid_o (rr_valid),
        .out_ready_i (out_ready),
        .out_idx_o   (rr_idx),
        .pending_o   (rr_pend),
        .overflow_o  (rr_ovf)
    );

    function automatic model_t reset_state();
        model_t s;
        s.pend  = '0;
        s.valid = 1'b0;
        s.idx   = 0;
        s.ptr   = N - 1;
        s.ovf   = 1'b0;
        return s;
    endfunction

    // Pick the winner by walking the priority order directly, then issue it.
    function automatic model_t step(model_t s, logic [N-1:0] r, logic rdy, bit rr_mode, logic c);
        model_t n;
        int     sel;
        int     b;
        bit     loaded;
        if (c) return reset_state();
        n   = s;
        sel = -1;
        for (int k = 0; k < N; k++) begin
            b = rr_mode ? (s.ptr - k + N) % N : (N - 1 - k);
            if (sel < 0 && s.pend[b]) sel = b;
        end
        loaded = 1'b0;
        if (!s.valid || rdy) begin
            if (sel >= 0) begin
                loaded      = 1'b1;
                n.valid     = 1'b1;
                n.idx       = sel;
                n.pend[sel] = 1'b0;
                n.ptr       = (sel == 0) ? N - 1 : sel - 1;
            end else begin
                n.valid = 1'b0;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (r[i] && s.pend[i] && !(loaded && i == sel)) n.ovf = 1'b1;
        end
        n.pend = n.pend | r;
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_fx <= reset_state();
            m_rr <= reset_state();
        end else begin
            m_fx <= step(m_fx, req, out_ready, 1'b0, clr);
            m_rr <= step(m_rr, req, out_ready, 1'b1, clr);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("fix.valid",   64'(fx_valid), 64'(m_fx.valid));
            check("fix.idx",     64'(fx_idx),   64'(m_fx.idx));
            check("fix.pending", 64'(fx_pend),  64'(m_fx.pend));
            check("fix.ovf",     64'(fx_ovf),   64'(m_fx.ovf));
            check("rr.valid",    64'(rr_valid), 64'(m_rr.valid));
            check("rr.idx",      64'(rr_idx),   64'(m_rr.idx));
            check("rr.pending",  64'(rr_pend),  64'(m_rr.pend));
            check("rr.ovf",      64'(rr_ovf),   64'(m_rr.ovf));
        end
    end

    // Apply inputs, let one rising edge sample them, return 2 time units later.
    task automatic drive(input logic [N-1:0] r, input logic rdy, input logic c);
        req       = r;
        out_ready = rdy;
        clr       = c;
        @(posedge clk);
        #2;
    endtask

    initial begin
        // Reset state
        #12;
        check("rst.valid", 64'(fx_valid), 64'd0);
        check("rst.idx",   64'(rr_idx),   64'd0);
        check("rst.pend",  64'(fx_pend),  64'd0);
        check("rst.ovf",   64'(rr_ovf),   64'd0);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        @(posedge clk);
        #2;

        // Fixed priority drain of 5,2,0
        drive(10'b0000100101, 1'b1, 1'b0);
        drive('0, 1'b1, 1'b0);
        check("t1.idx5", 64'(fx_idx), 64'd5);
        drive('0, 1'b1, 1'b0);
        check("t1.idx2", 64'(fx_idx), 64'd2);
        drive('0, 1'b1, 1'b0);
        check("t1.idx0", 64'(fx_idx), 64'd0);
        check("t1.val0", 64'(fx_valid), 64'd1);
        drive('0, 1'b1, 1'b0);
        check("t1.idle", 64'(fx_valid), 64'd0);

        // Backpressure holds index 9
        drive(10'b1000001000, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            drive('0, 1'b0, 1'b0);
            check("t2.hold_idx",  64'(fx_idx),   64'd9);
            check("t2.hold_val",  64'(fx_valid), 64'd1);
            check("t2.hold_pend", 64'(fx_pend),  64'h008);
        end
        drive('0, 1'b1, 1'b0);
        check("t2.idx3", 64'(fx_idx), 64'd3);
        drive('0, 1'b1, 1'b0);
        check("t2.idle", 64'(fx_valid), 64'd0);

        // All requests held: round-robin rotates, fixed sticks at 9
        drive('0, 1'b1, 1'b1);
        drive('1, 1'b1, 1'b0);
        for (int j = 0; j < 12; j++) begin
            drive('1, 1'b1, 1'b0);
            check("t3.rr_idx",  64'(rr_idx), 64'(9 - (j % 10)));
            check("t3.fix_idx", 64'(fx_idx), 64'd9);
            if (j == 0) begin
                check("t3.rr_ovf",  64'(rr_ovf), 64'd1);
                check("t3.fix_ovf", 64'(fx_ovf), 64'd1);
            end
        end

        // Overflow while stalled, then clear beats request
        drive('0, 1'b1, 1'b1);
        drive(10'h001, 1'b1, 1'b0);
        drive('0, 1'b0, 1'b0);
        check("t4.slot0", 64'(fx_idx), 64'd0);
        drive(10'h008, 1'b0, 1'b0);
        check("t4.no_ovf", 64'(fx_ovf), 64'd0);
        drive(10'h008, 1'b0, 1'b0);
        check("t4.ovf_fix", 64'(fx_ovf), 64'd1);
        check("t4.ovf_rr",  64'(rr_ovf), 64'd1);
        drive(10'h001, 1'b0, 1'b1);
        check("t4.clr_pend", 64'(fx_pend),  64'd0);
        check("t4.clr_ovf",  64'(fx_ovf),   64'd0);
        check("t4.clr_val",  64'(rr_valid), 64'd0);

        // Asynchronous reset mid-stream
        drive(10'h100, 1'b1, 1'b0);
        drive(10'h0F0, 1'b0, 1'b0);
        check("t5.pre_pend", 64'(fx_pend),  64'h0F0);
        check("t5.pre_val",  64'(fx_valid), 64'd1);
        check("t5.pre_idx",  64'(rr_idx),   64'd8);
        #1 rst_n = 1'b0;
        #1;
        check("t5.fix_val",  64'(fx_valid), 64'd0);
        check("t5.fix_idx",  64'(fx_idx),   64'd0);
        check("t5.fix_pend", 64'(fx_pend),  64'd0);
        check("t5.rr_val",   64'(rr_valid), 64'd0);
        check("t5.rr_idx",   64'(rr_idx),   64'd0);
        check("t5.rr_ovf",   64'(rr_ovf),   64'd0);
        req       = '0;
        out_ready = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;

        // Randomised traffic, stalls and occasional clears
        for (int i = 0; i < 1500; i++) begin
            drive(N'($urandom & $urandom & $urandom),
                  1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 63) == 0));
        end
        drive('0, 1'b1, 1'b0);
        chk_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
